// File: rtl/mem_bus_pkg.sv
// Shared MemoryBus types and default bus widths for the arbiter slice.
package mem_bus_pkg;

  localparam int DATA_W_DEF = 24;
  localparam int ADDR_W_DEF = 32;
  localparam int ID_W_DEF   = 8;

  typedef struct packed {
    logic [ID_W_DEF-1:0]   id;
    logic [ADDR_W_DEF-1:0] address;
    logic [DATA_W_DEF-1:0] data;
    logic                  write;
  } mem_req_t;

  typedef struct packed {
    logic [ID_W_DEF-1:0]   id;
    logic [DATA_W_DEF-1:0] data;
  } mem_rsp_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: combinational one-hot grant from a rotating pointer,
// pointer moves past the winner whenever a grant is issued.
module rr_arbiter #(
  parameter  int N  = 4,
  localparam int IW = $clog2(N)
) (
  input  logic          clock,
  input  logic          reset,
  input  logic [N-1:0]  request,
  input  logic          advance,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] grantIndex
);

  logic [IW-1:0] ptr_q, ptr_d;
  logic [IW-1:0] cand;
  logic          found;
  int            sum;

  always_comb begin
    found      = 1'b0;
    grantIndex = '0;
    grant      = '0;
    cand       = '0;
    sum        = 0;
    for (int i = 0; i < N; i++) begin
      sum  = int'(ptr_q) + i;
      if (sum >= N) sum = sum - N;
      cand = IW'(sum);
      if (!found && request[cand]) begin
        found      = 1'b1;
        grantIndex = cand;
      end
    end
    if (advance && found) grant[grantIndex] = 1'b1;
  end

  always_comb begin
    ptr_d = ptr_q;
    if (advance && found)
      ptr_d = (grantIndex == IW'(N-1)) ? '0 : grantIndex + IW'(1);
  end

  always_ff @(posedge clock) begin
    if (reset) ptr_q <= '0;
    else       ptr_q <= ptr_d;
  end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Shares one MemoryBus port between NUM_PORTS requesters; responses routed by ID.
// Optional MEM_BUS_ARBITER_PERF_EN adds grant and stall counters.
module mem_bus_arbiter
  import mem_bus_pkg::*;
#(
  parameter int NUM_PORTS       = 4,
  parameter int DATA_WIDTH      = DATA_W_DEF,
  parameter int ADDRESS_WIDTH   = ADDR_W_DEF,
  parameter int MASTER_ID_WIDTH = ID_W_DEF,
  parameter logic [MASTER_ID_WIDTH-1:0] ID_BASE = MASTER_ID_WIDTH'(4),
  parameter int IDS_PER_PORT    = 4
) (
  input  logic                                 clock,
  input  logic                                 reset,
  input  logic [NUM_PORTS*MASTER_ID_WIDTH-1:0] rqID,
  input  logic [NUM_PORTS*ADDRESS_WIDTH-1:0]   rqAddress,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0]      rqData,
  input  logic [NUM_PORTS-1:0]                 rqWrite,
  input  logic [NUM_PORTS-1:0]                 rqValid,
  output logic [NUM_PORTS-1:0]                 rqTaken,
  output logic [DATA_WIDTH-1:0]                rsData,
  output logic [MASTER_ID_WIDTH-1:0]           rsID,
  output logic [NUM_PORTS-1:0]                 rsValid,
  input  logic [NUM_PORTS-1:0]                 rsTaken,
  output logic [MASTER_ID_WIDTH-1:0]           msID,
  output logic [ADDRESS_WIDTH-1:0]             msAddress,
  output logic [DATA_WIDTH-1:0]                msData,
  output logic                                 msWrite,
  output logic                                 msValid,
  input  logic                                 msTaken,
  input  logic [MASTER_ID_WIDTH-1:0]           smID,
  input  logic [DATA_WIDTH-1:0]                smData,
  input  logic                                 smValid,
  output logic                                 smTaken,
  output logic                                 idError
`ifdef MEM_BUS_ARBITER_PERF_EN
  ,
  output logic [NUM_PORTS*16-1:0]              grantCount,
  output logic [15:0]                          stallCycles
`endif
);

  localparam int PIW = $clog2(NUM_PORTS);
  localparam int SH  = $clog2(IDS_PER_PORT);

  logic [NUM_PORTS-1:0]       grant;
  logic [PIW-1:0]             gidx;
  logic                       load;
  logic                       msValid_q, msValid_d;
  logic [MASTER_ID_WIDTH-1:0] msID_q, msID_d;
  logic [ADDRESS_WIDTH-1:0]   msAddress_q, msAddress_d;
  logic [DATA_WIDTH-1:0]      msData_q, msData_d;
  logic                       msWrite_q, msWrite_d;

  // The output register may accept a new request when empty or draining this cycle.
  assign load = !msValid_q || msTaken;

  rr_arbiter #(.N(NUM_PORTS)) u_arb (
    .clock      (clock),
    .reset      (reset),
    .request    (rqValid),
    .advance    (load && !reset),
    .grant      (grant),
    .grantIndex (gidx)
  );

  assign rqTaken = grant;

  always_comb begin
    msValid_d   = msValid_q;
    msID_d      = msID_q;
    msAddress_d = msAddress_q;
    msData_d    = msData_q;
    msWrite_d   = msWrite_q;
    if (load) begin
      msValid_d = |grant;
      if (|grant) begin
        msID_d      = rqID[int'(gidx)*MASTER_ID_WIDTH +: MASTER_ID_WIDTH];
        msAddress_d = rqAddress[int'(gidx)*ADDRESS_WIDTH +: ADDRESS_WIDTH];
        msData_d    = rqData[int'(gidx)*DATA_WIDTH +: DATA_WIDTH];
        msWrite_d   = rqWrite[gidx];
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) msValid_q <= 1'b0;
    else       msValid_q <= msValid_d;
  end

  always_ff @(posedge clock) begin
    msID_q      <= msID_d;
    msAddress_q <= msAddress_d;
    msData_q    <= msData_d;
    msWrite_q   <= msWrite_d;
  end

  assign msValid   = msValid_q;
  assign msID      = msID_q;
  assign msAddress = msAddress_q;
  assign msData    = msData_q;
  assign msWrite   = msWrite_q;

  logic [MASTER_ID_WIDTH-1:0] rsOff, rsOwner;
  logic                       owned;
  logic                       idError_q, idError_d;

  // IDS_PER_PORT is a power of two, so the owner lookup is a subtract and shift.
  assign rsOff   = smID - ID_BASE;
  assign rsOwner = rsOff >> SH;
  assign owned   = (smID >= ID_BASE) && (rsOwner < MASTER_ID_WIDTH'(NUM_PORTS));
  assign rsID    = smID;
  assign rsData  = smData;

  always_comb begin
    rsValid = '0;
    smTaken = smValid && !owned;
    for (int p = 0; p < NUM_PORTS; p++) begin
      if (owned && rsOwner == MASTER_ID_WIDTH'(p)) begin
        rsValid[p] = smValid;
        smTaken    = smValid && rsTaken[p];
      end
    end
  end

  assign idError_d = idError_q || (smValid && !owned);

  always_ff @(posedge clock) begin
    if (reset) idError_q <= 1'b0;
    else       idError_q <= idError_d;
  end

  assign idError = idError_q;

`ifdef MEM_BUS_ARBITER_PERF_EN
  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (&v) ? v : v + 16'd1;
  endfunction

  logic [15:0] grantCnt_q [NUM_PORTS];
  logic [15:0] stall_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int p = 0; p < NUM_PORTS; p++) grantCnt_q[p] <= '0;
      stall_q <= '0;
    end else begin
      for (int p = 0; p < NUM_PORTS; p++)
        if (grant[p]) grantCnt_q[p] <= sat_inc(grantCnt_q[p]);
      if (msValid_q && !msTaken) stall_q <= sat_inc(stall_q);
    end
  end

  always_comb begin
    grantCount = '0;
    for (int p = 0; p < NUM_PORTS; p++) grantCount[p*16 +: 16] = grantCnt_q[p];
  end

  assign stallCycles = stall_q;
`endif

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed self-checking bench for mem_bus_arbiter (default 4-port configuration).
module tb_mem_bus_arbiter;

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] rqID;
  logic [127:0] rqAddress;
  logic [95:0] rqData;
  logic [3:0]  rqWrite, rqValid, rqTaken, rsValid, rsTaken;
  logic [23:0] rsData, msData, smData;
  logic [7:0]  rsID, msID, smID;
  logic [31:0] msAddress;
  logic        msWrite, msValid, msTaken, smValid, smTaken, idError;
`ifdef MEM_BUS_ARBITER_PERF_EN
  logic [63:0] grantCount;
  logic [15:0] stallCycles;
`endif

  int n_vec = 0;
  int n_err = 0;

  always #5 clock = ~clock;

  mem_bus_arbiter dut (
    .clock(clock), .reset(reset),
    .rqID(rqID), .rqAddress(rqAddress), .rqData(rqData), .rqWrite(rqWrite),
    .rqValid(rqValid), .rqTaken(rqTaken),
    .rsData(rsData), .rsID(rsID), .rsValid(rsValid), .rsTaken(rsTaken),
    .msID(msID), .msAddress(msAddress), .msData(msData), .msWrite(msWrite),
    .msValid(msValid), .msTaken(msTaken),
    .smID(smID), .smData(smData), .smValid(smValid), .smTaken(smTaken),
    .idError(idError)
`ifdef MEM_BUS_ARBITER_PERF_EN
    , .grantCount(grantCount), .stallCycles(stallCycles)
`endif
  );

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic set_port(input int k, input logic [7:0] id, input logic [31:0] addr,
                          input logic [23:0] data, input logic wr);
    rqID[k*8 +: 8]        = id;
    rqAddress[k*32 +: 32] = addr;
    rqData[k*24 +: 24]    = data;
    rqWrite[k]            = wr;
  endtask

  task automatic init_ports();
    for (int k = 0; k < 4; k++)
      set_port(k, 8'(4 + 4*k), 32'h1000 + 32'(16*k), 24'hA00000 + 24'(k), k[0]);
  endtask

  task automatic reset_pulse();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; rqValid = '0; rsTaken = '0; msTaken = 1'b0;
    smValid = 1'b0; smID = '0; smData = '0;
    init_ports();
    tick();
    n_vec++; if (msValid !== 1'b0) begin n_err++; $display("FAIL reset_msValid: got %b expected 0", msValid); end
    n_vec++; if (rqTaken !== 4'b0000) begin n_err++; $display("FAIL reset_rqTaken: got %b expected 0000", rqTaken); end
    n_vec++; if (rsValid !== 4'b0000) begin n_err++; $display("FAIL reset_rsValid: got %b expected 0000", rsValid); end
    n_vec++; if (smTaken !== 1'b0) begin n_err++; $display("FAIL reset_smTaken: got %b expected 0", smTaken); end
    n_vec++; if (idError !== 1'b0) begin n_err++; $display("FAIL reset_idError: got %b expected 0", idError); end
    reset = 1'b0;
  endtask

  task automatic test_single();
    set_port(2, 8'd12, 32'h100, 24'h00BEEF, 1'b0);
    rqValid = 4'b0100; msTaken = 1'b1;
    #1;
    n_vec++; if (rqTaken !== 4'b0100) begin n_err++; $display("FAIL single_rqTaken: got %b expected 0100", rqTaken); end
    tick();
    rqValid = '0;
    #1;
    n_vec++; if (msValid !== 1'b1) begin n_err++; $display("FAIL single_msValid: got %b expected 1", msValid); end
    n_vec++; if (msAddress !== 32'h100) begin n_err++; $display("FAIL single_msAddress: got %h expected 00000100", msAddress); end
    n_vec++; if (msID !== 8'd12) begin n_err++; $display("FAIL single_msID: got %0d expected 12", msID); end
    n_vec++; if (msData !== 24'h00BEEF) begin n_err++; $display("FAIL single_msData: got %h expected 00beef", msData); end
    n_vec++; if (rqTaken !== 4'b0000) begin n_err++; $display("FAIL single_noTaken: got %b expected 0000", rqTaken); end
    tick();
    n_vec++; if (msValid !== 1'b0) begin n_err++; $display("FAIL single_drain: got %b expected 0", msValid); end
    init_ports();
  endtask

  task automatic test_round_robin();
    logic [3:0] exp_t;
    logic [7:0] exp_id;
    reset_pulse();
    rqValid = 4'b1111; msTaken = 1'b1;
    for (int i = 0; i < 6; i++) begin
      #1;
      exp_t = 4'b0001 << (i % 4);
      n_vec++; if (rqTaken !== exp_t) begin n_err++; $display("FAIL rr_grant%0d: got %b expected %b", i, rqTaken, exp_t); end
      if (i > 0) begin
        exp_id = 8'(4 + 4*((i-1) % 4));
        n_vec++; if (msValid !== 1'b1 || msID !== exp_id) begin n_err++; $display("FAIL rr_out%0d: got valid=%b id=%0d expected valid=1 id=%0d", i, msValid, msID, exp_id); end
      end
      tick();
    end
    n_vec++; if (msValid !== 1'b1 || msID !== 8'd8) begin n_err++; $display("FAIL rr_last: got valid=%b id=%0d expected valid=1 id=8", msValid, msID); end
    rqValid = '0;
    tick();
  endtask

  task automatic test_hold();
    reset_pulse();
    rqValid = 4'b0011; msTaken = 1'b0;
    #1;
    n_vec++; if (rqTaken !== 4'b0001) begin n_err++; $display("FAIL hold_first: got %b expected 0001", rqTaken); end
    tick();
    for (int i = 0; i < 5; i++) begin
      n_vec++;
      if (msValid !== 1'b1 || msID !== 8'd4 || msAddress !== 32'h1000 || rqTaken !== 4'b0000) begin
        n_err++;
        $display("FAIL hold_cycle%0d: got valid=%b id=%0d addr=%h taken=%b expected valid=1 id=4 addr=00001000 taken=0000",
                 i, msValid, msID, msAddress, rqTaken);
      end
      tick();
    end
    msTaken = 1'b1;
    #1;
    n_vec++; if (rqTaken !== 4'b0010) begin n_err++; $display("FAIL hold_release: got %b expected 0010", rqTaken); end
    tick();
    n_vec++; if (msID !== 8'd8 || msAddress !== 32'h1010) begin n_err++; $display("FAIL hold_next: got id=%0d addr=%h expected id=8 addr=00001010", msID, msAddress); end
    rqValid = '0;
    tick();
  endtask

  task automatic test_responses();
    smValid = 1'b1; smData = 24'h123456; smID = 8'd4; rsTaken = 4'b0001;
    #1;
    n_vec++; if (rsValid !== 4'b0001 || smTaken !== 1'b1) begin n_err++; $display("FAIL rsp_id4: got rsValid=%b smTaken=%b expected 0001 1", rsValid, smTaken); end
    n_vec++; if (rsID !== 8'd4 || rsData !== 24'h123456) begin n_err++; $display("FAIL rsp_bcast: got id=%0d data=%h expected 4 123456", rsID, rsData); end
    tick();
    smID = 8'd13; rsTaken = 4'b0100;
    #1;
    n_vec++; if (rsValid !== 4'b0100 || smTaken !== 1'b1) begin n_err++; $display("FAIL rsp_id13: got rsValid=%b smTaken=%b expected 0100 1", rsValid, smTaken); end
    tick();
    smID = 8'd19; rsTaken = 4'b1000;
    #1;
    n_vec++; if (rsValid !== 4'b1000 || smTaken !== 1'b1) begin n_err++; $display("FAIL rsp_id19: got rsValid=%b smTaken=%b expected 1000 1", rsValid, smTaken); end
    n_vec++; if (idError !== 1'b0) begin n_err++; $display("FAIL rsp_noerr: got %b expected 0", idError); end
    tick();
    smID = 8'd20; rsTaken = 4'b1111;
    #1;
    n_vec++; if (rsValid !== 4'b0000 || smTaken !== 1'b1) begin n_err++; $display("FAIL rsp_id20: got rsValid=%b smTaken=%b expected 0000 1", rsValid, smTaken); end
    tick();
    n_vec++; if (idError !== 1'b1) begin n_err++; $display("FAIL rsp_err_set: got %b expected 1", idError); end
    smID = 8'd3; rsTaken = 4'b0000;
    #1;
    n_vec++; if (rsValid !== 4'b0000 || smTaken !== 1'b1) begin n_err++; $display("FAIL rsp_id3: got rsValid=%b smTaken=%b expected 0000 1", rsValid, smTaken); end
    tick();
    smValid = 1'b0; smID = 8'd4;
    tick();
    tick();
    n_vec++; if (idError !== 1'b1) begin n_err++; $display("FAIL rsp_err_sticky: got %b expected 1", idError); end
  endtask

  task automatic test_backpressure();
    smValid = 1'b1; smID = 8'd9; rsTaken = 4'b0000;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_vec++; if (smTaken !== 1'b0 || rsValid !== 4'b0010) begin n_err++; $display("FAIL bp_stall%0d: got smTaken=%b rsValid=%b expected 0 0010", i, smTaken, rsValid); end
      tick();
    end
    rsTaken = 4'b0010;
    #1;
    n_vec++; if (smTaken !== 1'b1) begin n_err++; $display("FAIL bp_release: got %b expected 1", smTaken); end
    tick();
    smValid = 1'b0; rsTaken = '0;
  endtask

  task automatic test_reset_mid();
    // Pointer sits at 2 after test_hold; port 1 alone wins and leaves it at 2.
    rqValid = 4'b0010; msTaken = 1'b0;
    #1;
    n_vec++; if (rqTaken !== 4'b0010) begin n_err++; $display("FAIL mid_setup: got %b expected 0010", rqTaken); end
    tick();
    rqValid = 4'b1111;
    n_vec++; if (msValid !== 1'b1 || idError !== 1'b1) begin n_err++; $display("FAIL mid_pre: got valid=%b idError=%b expected 1 1", msValid, idError); end
    reset = 1'b1;
    tick();
    n_vec++; if (msValid !== 1'b0 || idError !== 1'b0) begin n_err++; $display("FAIL mid_reset: got valid=%b idError=%b expected 0 0", msValid, idError); end
    reset = 1'b0; msTaken = 1'b1;
    #1;
    n_vec++; if (rqTaken !== 4'b0001) begin n_err++; $display("FAIL mid_first_grant: got %b expected 0001", rqTaken); end
    tick();
    n_vec++; if (msValid !== 1'b1 || msID !== 8'd4) begin n_err++; $display("FAIL mid_first_out: got valid=%b id=%0d expected 1 4", msValid, msID); end
    rqValid = '0;
    tick();
  endtask

  initial begin
    rqID = '0; rqAddress = '0; rqData = '0; rqWrite = '0;
    test_reset();
    test_single();
    test_round_robin();
    test_hold();
    test_responses();
    test_backpressure();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
- Shares one MemoryBus memory port between NUM_PORTS requesters, e.g. several ray tracer instances plus a DMA engine.
- Request channel: round-robin arbitration into a one-entry registered output stage.
- Response channel: demultiplexed back to the owning requester by master ID.
- Sits between the requester memoryPorts and the memory controller slave port.

Parameters:
- NUM_PORTS, 4, number of requester ports (2..8).
- DATA_WIDTH, 24, bus data width.
- ADDRESS_WIDTH, 32, bus address width.
- MASTER_ID_WIDTH, 8, ID width.
- ID_BASE, 8'd4, first master ID owned by port 0.
- IDS_PER_PORT, 4, contiguous IDs owned by each port; port k owns [ID_BASE+k*IDS_PER_PORT, ID_BASE+(k+1)*IDS_PER_PORT).

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high reset
- rqID  in  NUM_PORTS*MASTER_ID_WIDTH  per-port request ID, port k in slice k
- rqAddress  in  NUM_PORTS*ADDRESS_WIDTH  per-port request address
- rqData  in  NUM_PORTS*DATA_WIDTH  per-port write data
- rqWrite  in  NUM_PORTS  per-port write flag
- rqValid  in  NUM_PORTS  per-port request valid
- rqTaken  out  NUM_PORTS  per-port request accepted
- rsData  out  DATA_WIDTH  response data, broadcast to all ports
- rsID  out  MASTER_ID_WIDTH  response ID, broadcast to all ports
- rsValid  out  NUM_PORTS  per-port response valid
- rsTaken  in  NUM_PORTS  per-port response accepted
- msID / msAddress / msData / msWrite  out  per bus widths  downstream request
- msValid  out  1  downstream request valid
- msTaken  in  1  downstream accepted request
- smID  in  MASTER_ID_WIDTH  downstream response ID
- smData  in  DATA_WIDTH  downstream response data
- smValid  in  1  downstream response valid
- smTaken  out  1  response accepted
- idError  out  1  sticky: response ID owned by no port

Behaviour:
- Reset (synchronous, active-high; outputs as seen after the first clock with reset=1):
  - msValid=0; rqTaken=0; rsValid=0; smTaken=0; idError=0.
  - Round-robin pointer = 0.
  - Any in-flight output-register contents are discarded.
- Transfer rule: a transfer occurs on a cycle where Valid && Taken. Requesters must hold Valid and payload stable until Taken.
- Output register load:
  - load = !msValid || msTaken.
  - When load, grant the first port with rqValid, searching from the pointer upward with wrap NUM_PORTS-1 -> 0.
  - Grant is combinational: assert rqTaken[g] that cycle (one-hot, at most one bit).
  - Capture port g's ID/address/data/write into the output register; msValid=1 next cycle.
  - Advance pointer to (g+1) mod NUM_PORTS.
  - When load and no port is valid: msValid drops to 0; pointer unchanged.
- Output hold: when msValid && !msTaken, all rqTaken=0 and register contents are held stable.
- Latency and throughput:
  - Request latency = 1 cycle (rqTaken cycle -> msValid next cycle).
  - Sustained throughput = 1 request/cycle while msTaken is held at 1.
- Fairness: with all ports continuously valid, grants follow 0,1,2,3,0,... No port waits more than NUM_PORTS-1 grants.
- Response path (combinational, no buffering):
  - Owner index k = (smID-ID_BASE)/IDS_PER_PORT. IDS_PER_PORT must be a power of two, so the divide is a shift.
  - rsValid[k] = smValid; all other rsValid bits = 0; smTaken = rsTaken[k].
  - rsID = smID and rsData = smData, driven unconditionally.
  - Unowned ID (smID<ID_BASE or k>=NUM_PORTS): smTaken=1 while smValid (response dropped); all rsValid=0; idError set, cleared only by reset.
- Request and response channels are independent; simultaneous events on both channels are legal.

Optional Feature:
- Macro: MEM_BUS_ARBITER_PERF_EN.
- Defined:
  - Adds output grantCount, width NUM_PORTS*16: one 16-bit saturating counter per port, incremented on each rqTaken[k]; reset to 0.
  - Adds output stallCycles, width 16, saturating: counts cycles with msValid && !msTaken; reset to 0.
- Undefined: neither port nor any counter logic exists; remaining behaviour is identical.

Decomposition:
- Shared package mem_bus_pkg holds:
  - typedef mem_req_t (id, address, data, write);
  - typedef mem_rsp_t (id, data);
  - localparam defaults for DATA_WIDTH, ADDRESS_WIDTH, MASTER_ID_WIDTH.
- Sub-module rr_arbiter: parameter N; inputs request[N], advance, clock, reset; outputs one-hot grant[N] and grantIndex. It owns the pointer.
- The top level instantiates rr_arbiter and implements the output register and response demux.

Test Plan:
- Single port: port 2 valid with address 0x100, msTaken=1 -> rqTaken[2] the same cycle; msValid next cycle with msAddress=0x100 and msID=port 2's ID; no other rqTaken.
- All 4 ports valid continuously, msTaken=1 -> grant order 0,1,2,3,0,1; one msValid per cycle with no bubbles.
- msTaken held 0 for 5 cycles with ports 0 and 1 valid -> msValid stays 1 with stable payload; all rqTaken=0; after msTaken rises, port 1 is granted next.
- Responses: smID=4 -> rsValid=0001; smID=13 -> rsValid=0100; smID=20 -> smTaken=1, rsValid=0, idError=1 and stays 1.
- Backpressure: smID=9 with rsTaken[1]=0 for 3 cycles -> smTaken=0 for those 3 cycles; smTaken=1 on the cycle rsTaken[1]=1.
- Reset mid-operation: assert reset while msValid=1 and pointer=2 -> next cycle msValid=0 and idError=0; with all ports valid after release, first grant is port 0.
